// File: rtl/mbist_pkg.sv
// Shared March C- definitions: element ids, per-element tables and FSM states.
// Each table is a 6-bit vector indexed by element id (bit n = element Mn).
package mbist_pkg;

  typedef logic [2:0] elem_t;

  localparam elem_t M0 = 3'd0;
  localparam elem_t M1 = 3'd1;
  localparam elem_t M2 = 3'd2;
  localparam elem_t M3 = 3'd3;
  localparam elem_t M4 = 3'd4;
  localparam elem_t M5 = 3'd5;

  // 1 = walk DEPTH-1 down to 0
  localparam logic [5:0] ELEM_DOWN      = 6'b011000;
  localparam logic [5:0] ELEM_HAS_READ  = 6'b111110;
  localparam logic [5:0] ELEM_HAS_WRITE = 6'b011111;
  // 1 = all-ones background, 0 = all-zeros
  localparam logic [5:0] ELEM_RD_ONE    = 6'b010100;
  localparam logic [5:0] ELEM_WR_ONE    = 6'b001010;

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

  function automatic elem_t next_elem(input elem_t e);
    return e + 3'd1;
  endfunction

endpackage

// File: rtl/mbist_rd_cmp.sv
// Read-compare pipe: tags each issued read, compares when memory data lands RD_LAT cycles later.
// Keeps a sticky fail flag, a saturating miscompare count and the location of the first miscompare.
module mbist_rd_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  push_exp_one,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  elem_t                 push_elem,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  logic                  pipe_vld  [RD_LAT];
  logic                  pipe_exp  [RD_LAT];
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LAT];
  elem_t                 pipe_elem [RD_LAT];

  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_exp;
  logic                  miscompare;

  assign out_vld    = pipe_vld[RD_LAT-1];
  assign out_exp    = {DATA_WIDTH{pipe_exp[RD_LAT-1]}};
  assign miscompare = out_vld && (mem_rdata != out_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_exp[i]  <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_elem[i] <= M0;
      end
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else begin
      pipe_vld[0]  <= push;
      pipe_exp[0]  <= push_exp_one;
      pipe_addr[0] <= push_addr;
      pipe_elem[0] <= push_elem;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
      end
      if (clr) begin
        fail       <= 1'b0;
        fail_count <= '0;
        fail_addr  <= '0;
        fail_elem  <= '0;
      end else if (miscompare) begin
        fail <= 1'b1;
        if (fail_count != '1)
          fail_count <= fail_count + CNT_WIDTH'(1);
        // location is latched only for the first miscompare of the run
        if (!fail) begin
          fail_addr <= pipe_addr[RD_LAT-1];
          fail_elem <= pipe_elem[RD_LAT-1];
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: walks six elements over addresses 0..DEPTH-1 and drives the memory pins.
// Run takes 10*DEPTH+6+RD_LAT cycles from start to done; start is ignored while busy.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int DCW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t         state;
  elem_t          elem;
  logic [DCW-1:0] drain_cnt;

  logic  accept;
  logic  down;
  logic  at_end;
  logic  read_then_write;
  elem_t elem_nxt;

  assign accept          = start && (state == IDLE || state == DONE);
  assign down            = ELEM_DOWN[elem];
  assign at_end          = down ? (mem_address == '0) : (mem_address == LAST_ADDR);
  assign read_then_write = !mem_write_read && ELEM_HAS_WRITE[elem];
  assign elem_nxt        = next_elem(elem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      elem           <= M0;
      drain_cnt      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= SETUP;
            elem           <= M0;
            busy           <= 1'b1;
            done           <= 1'b0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= {DATA_WIDTH{ELEM_WR_ONE[M0]}};
          end
        end
        SETUP: begin
          state          <= RUN;
          mem_write_read <= !ELEM_HAS_READ[elem];
          mem_address    <= down ? LAST_ADDR : '0;
        end
        RUN: begin
          if (read_then_write) begin
            mem_write_read <= 1'b1;
          end else if (!at_end) begin
            mem_address    <= down ? mem_address - ADDR_WIDTH'(1) : mem_address + ADDR_WIDTH'(1);
            mem_write_read <= !ELEM_HAS_READ[elem];
          end else if (elem == M5) begin
            state          <= DRAIN;
            mem_write_read <= 1'b0;
            drain_cnt      <= '0;
          end else begin
            // wdata switches one cycle ahead of the first write of the next element
            state          <= SETUP;
            elem           <= elem_nxt;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= {DATA_WIDTH{ELEM_WR_ONE[elem_nxt]}};
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(RD_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mbist_rd_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_rd_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (accept),
    .push         ((state == RUN) && !mem_write_read),
    .push_exp_one (ELEM_RD_ONE[elem]),
    .push_addr    (mem_address),
    .push_elem    (elem),
    .mem_rdata    (mem_rdata),
    .fail         (fail),
    .fail_count   (fail_count),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem)
  );

endmodule
